// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-block instruction cache sitting
// between the fetch stage and the memory controller instruction port.
// Hits are served combinationally; a miss fetches one word and fills the frame.
// Optional feature macro: ICACHE_STATS_EN enables the hit/miss counters;
// without it hit_count/miss_count read as zero and no counter flops exist.
module icache_direct #(
  parameter int SETS = 16,
  parameter int TAGW = 30 - $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX = $clog2(SETS);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e            state_q;
  logic [29:0]       miss_q;     // word address of the outstanding miss
  logic [SETS-1:0]   valid_q;
  logic [TAGW-1:0]   tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX-1:0]    req_idx;
  logic [TAGW-1:0]   req_tag;
  logic [IDX-1:0]    miss_idx;
  logic [TAGW-1:0]   miss_tag;
  logic              lookup_hit;
  logic              start_miss;
  logic              fill_en;
  logic              unused_addr_bits;

  assign req_idx  = imemaddr[IDX+1:2];
  assign req_tag  = imemaddr[31:IDX+2];
  assign miss_idx = miss_q[IDX-1:0];
  assign miss_tag = miss_q[29:IDX];

  // Byte offset within the word carries no information for a word cache.
  assign unused_addr_bits = ^imemaddr[1:0];

  // Raw lookup; flush and state qualify it below.
  assign lookup_hit = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

  // A miss is only launched from IDLE; flush suppresses it for that cycle.
  assign start_miss = (state_q == IDLE) & imemREN & ~lookup_hit & ~flush;

  // Fill on the cycle the controller delivers data, unless a flush aborts it.
  assign fill_en = (state_q == FETCH) & ~iwait & ~flush;

  // Control state: FSM, outstanding miss address and valid bits.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      miss_q  <= '0;
      valid_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end else if (fill_en) begin
        valid_q[miss_idx] <= 1'b1;
      end

      if (state_q == IDLE) begin
        if (start_miss) begin
          state_q <= FETCH;
          miss_q  <= imemaddr[31:2];
        end
      end else begin
        // Fill completes regardless of what the fetch stage does meanwhile.
        if (flush || !iwait) begin
          state_q <= IDLE;
        end
      end
    end
  end

  // Tag and data arrays hold no reset; valid_q alone decides hits.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      data_q[miss_idx] <= iload;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

  assign ihit     = nRST & (state_q == IDLE) & lookup_hit & ~flush;
  assign imemload = data_q[req_idx];
  assign iREN     = (state_q == FETCH);
  assign iaddr    = (state_q == FETCH) ? {miss_q, 2'b00} : 32'h0;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Statistics: hit cycles and launched misses; flush leaves them alone.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ihit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (start_miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: a driver issues fetches and pushes the
// expected responses, a monitor pops and checks them whenever ihit appears,
// and a memory responder answers fetches with random or forced stall lengths.
module tb_icache_direct;

  localparam int TB_SETS = 16;
  localparam int TB_IDX  = $clog2(TB_SETS);
  localparam int K_HIT   = 0;
  localparam int K_MISS  = 1;
  localparam int K_ANY   = 2;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_direct #(.SETS(TB_SETS)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    int          kind;
    int          issue;
  } exp_t;

  exp_t         sbq[$];
  logic [29:0]  cached[int];   // reference: index -> cached word address
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  bit           rst_edge = 0;
  bit           flush_edge = 0;
  int           exp_hits = 0;
  int           exp_miss = 0;
  logic [31:0]  exp_fetch_addr = 32'h0;
  int           force_w = -1;
  int           last_w = 0;
  int           fetch_starts = 0;
  int           fetch_base = 0;
  int           resp_cnt = 0;
  bit           resp_prev = 0;
  int           run_len = 0;
  bit           ren_prev = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    if (w == 30'h10) return 32'h2001_0005;
    return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic bit mhit(input logic [31:0] a);
    int i;
    i = int'(a[TB_IDX+1:2]);
    return cached.exists(i) && (cached[i] == a[31:2]);
  endfunction

  function automatic void madd(input logic [31:0] a);
    cached[int'(a[TB_IDX+1:2])] = a[31:2];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected DUT event (cycle %0d)", nm, cyc);
  endtask

  always @(posedge CLK) begin
    cyc        <= cyc + 1;
    rst_edge   <= !nRST;
    flush_edge <= flush;
  end

  // Memory controller model: stalls a chosen number of cycles, then returns data.
  initial begin
    iwait = 1'b1;
    iload = 32'h0;
    forever begin
      @(posedge CLK);
      #2;
      if (iREN === 1'b1) begin
        if (!resp_prev) begin
          resp_cnt = (force_w >= 0) ? force_w : int'($urandom_range(0, 3));
          last_w   = resp_cnt;
        end
        if (resp_cnt > 0) begin
          iwait = 1'b1;
          iload = $urandom;
          resp_cnt--;
        end else begin
          iwait = 1'b0;
          iload = memword(iaddr);
        end
      end else begin
        iwait = 1'($urandom_range(0, 1));
        iload = $urandom;
      end
      resp_prev = (iREN === 1'b1);
    end
  end

  // Monitor: protocol checks every cycle and scoreboard pop on each ihit.
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge CLK);
      if (cyc > 0) begin
        if (!nRST) chk("ihit_in_reset", {31'h0, ihit}, 32'h0);
        if (rst_edge) begin
          chk("rst_iREN", {31'h0, iREN}, 32'h0);
          chk("rst_iaddr", iaddr, 32'h0);
          chk("rst_hit_count", hit_count, 32'h0);
          chk("rst_miss_count", miss_count, 32'h0);
        end
        if (flush) chk("ihit_during_flush", {31'h0, ihit}, 32'h0);
        if (flush_edge) chk("iREN_after_flush", {31'h0, iREN}, 32'h0);
        if (iREN === 1'b1) begin
          chk("fetch_iaddr", iaddr, exp_fetch_addr);
          if (!ren_prev) fetch_starts++;
          run_len++;
        end else begin
          chk("idle_iaddr", iaddr, 32'h0);
          if (ren_prev && !rst_edge && !flush_edge)
            chk("iREN_run_length", run_len, last_w + 1);
          run_len = 0;
        end
        ren_prev = (iREN === 1'b1);
        if (ihit === 1'b1) begin
          if (sbq.size() == 0) begin
            chk("spurious_ihit", {31'h0, ihit}, 32'h0);
          end else begin
            e = sbq.pop_front();
            chk("imemload", imemload, e.data);
            lat = cyc - e.issue;
            if (e.kind == K_HIT) chk("hit_latency", lat, 0);
            else if (e.kind == K_MISS) chk("miss_latency", lat, last_w + 2);
          end
        end
      end
    end
  end

  task automatic wait_ihit(input string nm);
    bit got;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (ihit === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) tmo(nm);
    else exp_hits++;
  endtask

  task automatic wait_iren(input logic level, input string nm);
    bit got;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (iREN === level) begin
        got = 1;
        break;
      end
    end
    if (!got) tmo(nm);
  endtask

  // Issue one fetch and hold it until the cache answers.
  task automatic do_req(input logic [31:0] a, input int fw);
    exp_t e;
    bit   h;
    @(posedge CLK); #1;
    flush    = 1'b0;
    imemREN  = 1'b1;
    imemaddr = a;
    force_w  = fw;
    h        = mhit(a);
    e.data   = memword(a);
    e.kind   = h ? K_HIT : K_MISS;
    e.issue  = cyc;
    if (!h) begin
      exp_miss++;
      exp_fetch_addr = {a[31:2], 2'b00};
    end
    sbq.push_back(e);
    wait_ihit("req_response");
    force_w = -1;
    madd(a);
  endtask

  task automatic gap(input bit f);
    @(posedge CLK); #1;
    imemREN  = 1'b0;
    imemaddr = $urandom;
    flush    = f;
    if (f) cached.delete();
  endtask

  task automatic flush_with_req(input logic [31:0] a);
    @(posedge CLK); #1;
    imemREN  = 1'b1;
    imemaddr = a;
    flush    = 1'b1;
    cached.delete();
  endtask

  // Flush while the fill is stalled; the same request must be refetched.
  task automatic mid_fetch_flush(input logic [31:0] a);
    exp_t e;
    @(posedge CLK); #1;
    flush    = 1'b0;
    imemREN  = 1'b1;
    imemaddr = a;
    force_w  = 8;
    exp_fetch_addr = {a[31:2], 2'b00};
    exp_miss += 2;
    e.data = memword(a);
    e.kind = K_ANY;
    e.issue = cyc;
    sbq.push_back(e);
    wait_iren(1'b1, "midflush_fetch_start");
    @(posedge CLK); #1;
    flush   = 1'b1;
    force_w = -1;
    cached.delete();
    @(posedge CLK); #1;
    flush = 1'b0;
    wait_ihit("midflush_response");
    madd(a);
  endtask

  // Long stall with the request withdrawn mid-fill; the fill still lands.
  task automatic stall_drop(input logic [31:0] a);
    @(posedge CLK); #1;
    flush    = 1'b0;
    imemREN  = 1'b1;
    imemaddr = a;
    force_w  = 20;
    exp_fetch_addr = {a[31:2], 2'b00};
    exp_miss++;
    wait_iren(1'b1, "stall_fetch_start");
    @(posedge CLK); #1;
    imemREN  = 1'b0;
    imemaddr = $urandom;
    wait_iren(1'b0, "stall_fetch_end");
    force_w = -1;
    madd(a);
  endtask

  task automatic reset_mid_fetch(input logic [31:0] a);
    @(posedge CLK); #1;
    flush    = 1'b0;
    imemREN  = 1'b1;
    imemaddr = a;
    force_w  = 10;
    exp_fetch_addr = {a[31:2], 2'b00};
    wait_iren(1'b1, "rst_fetch_start");
    @(posedge CLK); #1;
    nRST    = 1'b0;
    imemREN = 1'b0;
    @(posedge CLK); #1;
    nRST       = 1'b1;
    force_w    = -1;
    exp_hits   = 0;
    exp_miss   = 0;
    fetch_base = fetch_starts;
    cached.delete();
  endtask

  task automatic check_ctrs(input string nm);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    flush   = 1'b0;
    @(negedge CLK);
`ifdef ICACHE_STATS_EN
    chk({nm, "_hit_count"}, hit_count, exp_hits);
    chk({nm, "_miss_count"}, miss_count, exp_miss);
`else
    chk({nm, "_hit_count"}, hit_count, 32'h0);
    chk({nm, "_miss_count"}, miss_count, 32'h0);
`endif
    chk({nm, "_fetches"}, fetch_starts - fetch_base, exp_miss);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [25:0] t;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    flush    = 1'b0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;

    do_req(32'h0000_0040, 3);
    check_ctrs("cold");
    do_req(32'h0000_0040, -1);
    do_req(32'h0000_0043, -1);
    check_ctrs("hit");
    do_req(32'h0000_0080, -1);
    do_req(32'h0000_0040, -1);
    check_ctrs("conflict");

    do_req(32'h0000_0044, -1);
    do_req(32'h0000_0040, -1);
    flush_with_req(32'h0000_0040);
    do_req(32'h0000_0040, -1);
    do_req(32'h0000_0044, -1);
    check_ctrs("flush");

    mid_fetch_flush(32'h0000_0100);
    check_ctrs("midflush");
    do_req(32'h0000_0100, -1);

    stall_drop(32'h0000_02C0);
    do_req(32'h0000_02C0, -1);
    check_ctrs("stall");

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) gap($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0: t = 26'h0;
        1: t = 26'h1;
        2: t = 26'h2;
        3: t = 26'h3;
        default: t = 26'h3FF_FFFF;
      endcase
      a = {t, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      do_req(a, -1);
    end
    check_ctrs("random");

    gap(1'b1);
    reset_mid_fetch(32'h0000_003C);
    check_ctrs("after_reset");
    do_req(32'h0000_0040, -1);
    check_ctrs("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
